mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit between the core's execute stage and the 32-bit data-memory bus. It takes a single-cycle access request carrying address, store data, write-enable and the 3-bit access mode. It drives one word-aligned bus transaction with byte enables and waits for the acknowledge. For loads it returns the lane-aligned, sign- or zero-extended result. `stall` holds the core's Fetch/Execute sequencing while a transaction is in flight.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for `bus_ack`; 0 disables the timeout.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `mode`  in  3  bit 2: sign-extend (loads only). Bits [1:0]: 00 word, 01 half, 10 byte, 11 invalid.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, taken from the low bits.
- `load_data`  out  32  formatted load result.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse, coincident with `done`.
- `stall`  out  1  high whenever not IDLE.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write.
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_rdata`  in  32  read data; valid when `bus_ack` is high.
- `bus_ack`  in  1  transaction accepted or completed.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE, `req`=1, aligned:**
  - Latch `we`, `mode`, `addr[1:0]`, the bus address, byte enables and store data.
  - Load the timeout counter with `TIMEOUT_CYCLES`.
  - Go to ACCESS.
- **IDLE, `req`=1, misaligned or invalid:**
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0. Invalid means `mode[1:0]`=11.
  - Go to RESP with the error flag set.
  - No bus transaction; `load_data` unchanged.
- **ACCESS:**
  - `bus_req`=1, and all bus outputs stay stable until `bus_ack` is sampled high.
  - `bus_ack`=1 → for loads, register the formatted `load_data`; go to RESP with the error flag clear.
  - Otherwise, if `TIMEOUT_CYCLES`≠0, decrement the counter; on reaching 0, drop to RESP with the error flag set and `load_data` unchanged.
- **RESP:** `done`=1, `err`=error flag; next state is IDLE.
- **Byte enables:**
  - Word → 1111.
  - Half → 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - Byte → `4'b0001 << addr[1:0]`.
  - Enables are driven for loads as well.
- **Store data:** byte is replicated `{4{wdata[7:0]}}`; half is `{2{wdata[15:0]}}`; word is passed unchanged.
- **Load formatting:**
  - The selected lane (byte index `addr[1:0]`, half index `addr[1]`) is shifted down to bit 0.
  - `mode[2]`=1 sign-extends from bit 7 or 15; `mode[2]`=0 zero-extends.
  - `mode[2]` is ignored for stores and for word loads.
- **Outputs:** `stall` = (state≠IDLE). `bus_we` = latched `we`.
- **Busy requests:** `req` while not IDLE is ignored (not queued); the core must hold the request until `done`.
- **`load_data` holding:** retains its last value across stores and errors until the next successful load.

## Timing
- **Reset values:** state=IDLE; `load_data`=0; `done`, `err`, `stall`, `bus_req`, `bus_we` = 0; `bus_addr`, `bus_be`, `bus_wdata` = 0.
- **Reset mid-transaction:** `bus_req` deasserts asynchronously and the transaction is abandoned; no `done` is produced.
- **Aligned request:**
  - `req` sampled at edge N → `bus_req` high from edge N.
  - `bus_ack` high at edge N+k (k≥1) → `done` high for the cycle from edge N+k to N+k+1. `load_data` is valid from edge N+k.
  - Minimum latency from request to done: 1 cycle of `bus_req`, then 1 cycle of `done`. Next request is accepted at edge N+k+2.
- **Misaligned request:** `req` at edge N → `done`/`err` high in the cycle after edge N; `bus_req` is never asserted.
- **Timeout:** `bus_req` is high for exactly `TIMEOUT_CYCLES` cycles, then `done`/`err` for one cycle.
- **Ack outside ACCESS:** `bus_ack` in any other state is ignored.

## Test plan
- LW `addr`=0x100, `bus_rdata`=0xDEADBEEF, ack on the first ACCESS cycle → `bus_addr`=0x100, `bus_be`=1111, `done` 2 cycles after `req`, `load_data`=0xDEADBEEF, `err`=0.
- LB `addr`=0x103, `bus_rdata`=0x80123456 → `bus_be`=1000, `load_data`=0xFFFFFF80. LBU with the same data → 0x00000080. LHU `addr`=0x102 → 0x00008012.
- SH `addr`=0x22, `wdata`=0x1234ABCD, ack after 3 wait cycles → `bus_addr`=0x20, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_we`=1, outputs stable over all 4 `bus_req` cycles; `load_data` unchanged.
- LH `addr`=0x21, or `mode`=011 → `err`+`done` one cycle after `req`, `bus_req` never high, `load_data` unchanged.
- `TIMEOUT_CYCLES`=4, `bus_ack` tied low → `bus_req` high exactly 4 cycles, then `done`=`err`=1, then IDLE; a second `req` held through busy is ignored until IDLE.
- `reset` pulsed mid-ACCESS → `bus_req`, `stall`=0 immediately, `load_data`=0, no `done`; the next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one execute-stage access into a word-aligned bus
// transaction with byte enables, and formats load data back for the core.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  mode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [2:0]         mode_q;
    logic [1:0]         lane_q;
    logic [31:0]        bus_addr_q;
    logic [3:0]         bus_be_q;
    logic [31:0]        bus_wdata_q;
    logic [31:0]        load_data_q, load_data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               bus_req_q, stall_q;
    logic               latch_en;

    logic               req_bad;
    logic [3:0]         req_be;
    logic [31:0]        req_wdata;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        rd_fmt;

    // Request decode: alignment check, byte enables and lane-replicated store data
    always_comb begin
        req_bad   = 1'b0;
        req_be    = 4'b1111;
        req_wdata = wdata_i;
        case (mode_i[1:0])
            2'b00: req_bad = (addr_i[1:0] != 2'b00);
            2'b01: begin
                req_bad   = addr_i[0];
                req_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                req_be    = 4'b0001 << addr_i[1:0];
                req_wdata = {4{wdata_i[7:0]}};
            end
            default: req_bad = 1'b1;
        endcase
    end

    // Lane select and extension of the returned read data
    always_comb begin
        rd_byte = bus_rdata_i[7:0];
        case (lane_q)
            2'd0: rd_byte = bus_rdata_i[7:0];
            2'd1: rd_byte = bus_rdata_i[15:8];
            2'd2: rd_byte = bus_rdata_i[23:16];
            2'd3: rd_byte = bus_rdata_i[31:24];
            default: rd_byte = bus_rdata_i[7:0];
        endcase
        rd_half = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (mode_q[1:0])
            2'b01:   rd_fmt = mode_q[2] ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
            2'b10:   rd_fmt = mode_q[2] ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
            default: rd_fmt = bus_rdata_i;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        latch_en    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (req_bad) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ACCESS;
                        latch_en = 1'b1;
                        cnt_d    = CNT_W'(TIMEOUT_CYCLES);
                    end
                end
            end
            ACCESS: begin
                if (bus_ack_i) begin
                    if (!we_q) begin
                        load_data_d = rd_fmt;
                    end
                    state_d = RESP;
                    done_d  = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mode_q      <= 3'b000;
            lane_q      <= 2'b00;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            load_data_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_req_q   <= (state_d == ACCESS);
            stall_q     <= (state_d != IDLE);
            if (latch_en) begin
                we_q        <= we_i;
                mode_q      <= mode_i;
                lane_q      <= addr_i[1:0];
                bus_addr_q  <= {addr_i[31:2], 2'b00};
                bus_be_q    <= req_be;
                bus_wdata_q <= req_wdata;
            end
        end
    end

    assign load_data_o = load_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign stall_o     = stall_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random accesses checked
// against an arithmetic model of the access rules.
module tb_mem_access_unit;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i, we_i;
    logic [2:0]  mode_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] load_data_o;
    logic        done_o, err_o, stall_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_ld = 32'h0;

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .we_i(we_i), .mode_i(mode_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .load_data_o(load_data_o), .done_o(done_o), .err_o(err_o), .stall_o(stall_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_bad(input logic [2:0] m, input logic [31:0] a);
        int sz = int'(m[1:0]);
        int lo = int'(a[1:0]);
        return (sz == 3) || (sz == 0 && lo != 0) || (sz == 1 && (lo % 2) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] m, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (m[1:0] == 2'b00) return 4'hF;
        if (m[1:0] == 2'b01) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'(1 << lo);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] m, input logic [31:0] w);
        if (m[1:0] == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
        if (m[1:0] == 2'b10) return (w & 32'hFF) * 32'h0101_0101;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rd);
        int lo = int'(a[1:0]);
        logic [31:0] v;
        if (m[1:0] == 2'b00) return rd;
        if (m[1:0] == 2'b01) begin
            v = (rd >> (16 * (lo / 2))) & 32'hFFFF;
            if (m[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = (rd >> (8 * lo)) & 32'hFF;
            if (m[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    // ack_at: bus_req cycle in which ack is given (0 = never)
    task automatic run_access(input logic w, input logic [2:0] m, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_at, input bit hold);
        @(negedge clk);
        req_i = 1'b1; we_i = w; mode_i = m; addr_i = a; wdata_i = wd;
        bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        @(posedge clk); #1;
        if (m_bad(m, a)) begin
            chk("bad_bus_req", 32'(bus_req_o), 32'h0);
            chk("bad_done", 32'(done_o), 32'h1);
            chk("bad_err", 32'(err_o), 32'h1);
            chk("bad_ld", load_data_o, exp_ld);
        end else begin
            for (int c = 1; c <= int'(T); c++) begin
                chk("acc_bus_req", 32'(bus_req_o), 32'h1);
                chk("acc_stall", 32'(stall_o), 32'h1);
                chk("acc_done", 32'(done_o), 32'h0);
                chk("acc_addr", bus_addr_o, a & 32'hFFFF_FFFC);
                chk("acc_be", 32'(bus_be_o), 32'(m_be(m, a)));
                chk("acc_wdata", bus_wdata_o, m_wd(m, wd));
                chk("acc_we", 32'(bus_we_o), 32'(w));
                @(negedge clk);
                if (!hold) req_i = 1'b0;
                bus_ack_i   = (c == ack_at);
                bus_rdata_i = (c == ack_at) ? rd : $urandom;
                @(posedge clk); #1;
                if (c == ack_at) begin
                    if (!w) exp_ld = m_load(m, a, rd);
                    chk("ack_done", 32'(done_o), 32'h1);
                    chk("ack_err", 32'(err_o), 32'h0);
                    chk("ack_ld", load_data_o, exp_ld);
                    chk("ack_bus_req", 32'(bus_req_o), 32'h0);
                    break;
                end else if (c == int'(T)) begin
                    chk("to_done", 32'(done_o), 32'h1);
                    chk("to_err", 32'(err_o), 32'h1);
                    chk("to_ld", load_data_o, exp_ld);
                    chk("to_bus_req", 32'(bus_req_o), 32'h0);
                end
            end
        end
        @(negedge clk);
        bus_ack_i = 1'b0;
        if (!hold) req_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 32'(done_o), 32'h0);
        chk("idle_stall", 32'(stall_o), 32'h0);
        chk("idle_bus_req", 32'(bus_req_o), 32'h0);
        if (hold) begin
            @(negedge clk);
            req_i = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; req_i = 1'b0; we_i = 1'b0; mode_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h0; bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        #1;
        chk("rst_ld", load_data_o, 32'h0);
        chk("rst_flags", {26'h0, done_o, err_o, stall_o, bus_req_o, bus_we_o, 1'b0}, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_be", 32'(bus_be_o), 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        run_access(1'b0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
        run_access(1'b0, 3'b110, 32'h103, 32'h0, 32'h80123456, 1, 1'b0);
        run_access(1'b0, 3'b010, 32'h103, 32'h0, 32'h80123456, 2, 1'b0);
        run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 1, 1'b0);
        run_access(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 4, 1'b0);
        run_access(1'b0, 3'b101, 32'h21, 32'h0, 32'h0, 1, 1'b0);
        run_access(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1, 1'b0);
        run_access(1'b0, 3'b000, 32'h200, 32'h0, 32'h0, 0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  m  = 3'($urandom);
            logic [31:0] a  = $urandom;
            logic        w  = 1'($urandom);
            if ($urandom_range(0, 3) != 0 && m[1:0] != 2'b10)
                a = (m[1:0] == 2'b00) ? (a & 32'hFFFF_FFFC) : (a & 32'hFFFF_FFFE);
            run_access(w, m, a, $urandom, $urandom, $urandom_range(1, 6), 1'($urandom));
        end

        // Make sure load_data is non-zero so the reset clear is observable
        run_access(1'b0, 3'b000, 32'h300, 32'h0, 32'hA5A5_1234, 1, 1'b0);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; mode_i = 3'b000; addr_i = 32'h40;
        @(posedge clk); #1;
        chk("pre_rst_bus_req", 32'(bus_req_o), 32'h1);
        @(negedge clk); req_i = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1; #1;
        exp_ld = 32'h0;
        chk("mid_rst_bus_req", 32'(bus_req_o), 32'h0);
        chk("mid_rst_stall", 32'(stall_o), 32'h0);
        chk("mid_rst_ld", load_data_o, exp_ld);
        chk("mid_rst_done", 32'(done_o), 32'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(done_o), 32'h0);
        run_access(1'b0, 3'b000, 32'h104, 32'h0, 32'h0BAD_F00D, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
